// File: rtl/eth_decap.sv
// eth_decap: receives a 64-bit MAC stream carrying NetTLP frames.
// It checks the Eth/IPv4/UDP header in beats 0-5 and forwards the payload
// (beats 6..) to the TLP FIFO. Each forwarded beat has its lanes reordered
// into big-endian 32-bit words.
module eth_decap #(
   parameter logic [15:0] eth_proto = 16'h0800,
   parameter logic [15:0] udp_dport = 16'h3000
) (
   input  logic        eth_clk,
   input  logic        eth_rst,
   input  logic        eth_tvalid,
   input  logic        eth_tlast,
   input  logic [7:0]  eth_tkeep,
   input  logic [63:0] eth_tdata,
   input  logic        eth_tuser,
   input  logic [47:0] adapter_reg_srcmac,
   input  logic [31:0] adapter_reg_srcip,
   output logic        wr_en,
   output logic [63:0] din_tdata,
   output logic [7:0]  din_tkeep,
   output logic        din_tlast,
   output logic        din_tuser,
   input  logic        full,
   input  logic        prog_full,
   output logic [15:0] rx_seq,
   output logic [31:0] rx_tstamp,
   output logic [31:0] rx_pkt_count,
   output logic [31:0] rx_drop_count,
   output logic        rx_ovf
);

   typedef enum logic [1:0] {RX_IDLE, RX_HDR, RX_TLP, RX_DROP} rx_state_t;

   rx_state_t   state_q;
   logic [2:0]  beat_q;
   logic        ip_hi_ok_q;
   logic        frm_ovf_q;
   logic        wr_en_q;
   logic [63:0] din_tdata_q;
   logic [7:0]  din_tkeep_q;
   logic        din_tlast_q;
   logic        din_tuser_q;
   logic [15:0] seq_q;
   logic [31:0] tstamp_q;
   logic [31:0] pkt_cnt_q;
   logic [31:0] drop_cnt_q;
   logic        ovf_q;

   logic [7:0]  b [8];
   logic [47:0] dmac;
   logic [15:0] dport;
   logic        dport_ok;
   logic        ip_hi_ok;
   logic        hdr_ok;
   logic [63:0] perm_data;
   logic [7:0]  perm_keep;

   // Split the input beat into frame-order bytes (byte k in lane k).
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         b[k] = eth_tdata[8*k +: 8];
      end
   end

   assign dmac     = {b[0], b[1], b[2], b[3], b[4], b[5]};
   assign dport    = {b[4], b[5]};
   // Compare in 17 bits so a window near 16'hFFFF cannot wrap around.
   assign dport_ok = ({1'b0, dport} >= {1'b0, udp_dport}) &&
                     ({1'b0, dport} <= ({1'b0, udp_dport} + 17'd15));
   // Upper half of the IP destination arrives one beat before the lower half.
   assign ip_hi_ok = ({b[6], b[7]} == adapter_reg_srcip[31:16]);

   // Lane reorder: FIFO word is {b4,b5,b6,b7,b0,b1,b2,b3}, b0 most significant of the low word.
   assign perm_data = {b[4], b[5], b[6], b[7], b[0], b[1], b[2], b[3]};
   assign perm_keep = {eth_tkeep[4], eth_tkeep[5], eth_tkeep[6], eth_tkeep[7],
                       eth_tkeep[0], eth_tkeep[1], eth_tkeep[2], eth_tkeep[3]};

   // Header check for the field(s) that complete on the current header beat.
   always_comb begin
      hdr_ok = 1'b1;
      case (beat_q)
         3'd0:    hdr_ok = (dmac == adapter_reg_srcmac) || (dmac == 48'hFFFF_FFFF_FFFF);
         3'd1:    hdr_ok = ({b[4], b[5]} == eth_proto) && (b[6] == 8'h45);
         3'd2:    hdr_ok = (b[7] == 8'd17);
         3'd4:    hdr_ok = ip_hi_ok_q && ({b[0], b[1]} == adapter_reg_srcip[15:0]) && dport_ok;
         default: hdr_ok = 1'b1;
      endcase
   end

   // Receive FSM with registered FIFO write port and status registers.
   always_ff @(posedge eth_clk) begin
      if (eth_rst) begin
         state_q     <= RX_IDLE;
         beat_q      <= '0;
         ip_hi_ok_q  <= 1'b0;
         frm_ovf_q   <= 1'b0;
         wr_en_q     <= 1'b0;
         din_tdata_q <= '0;
         din_tkeep_q <= '0;
         din_tlast_q <= 1'b0;
         din_tuser_q <= 1'b0;
         seq_q       <= '0;
         tstamp_q    <= '0;
         pkt_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            RX_IDLE, RX_HDR: begin
               if (eth_tvalid) begin
                  if (beat_q == 3'd3) begin
                     ip_hi_ok_q <= ip_hi_ok;
                  end
                  if (eth_tlast) begin
                     // Frame ends inside the header: runt (or failed and already over).
                     drop_cnt_q <= drop_cnt_q + 32'd1;
                     state_q    <= RX_IDLE;
                     beat_q     <= '0;
                  end else if (!hdr_ok) begin
                     state_q <= RX_DROP;
                     beat_q  <= '0;
                  end else if (beat_q == 3'd5) begin
                     beat_q <= '0;
                     if (prog_full) begin
                        state_q <= RX_DROP;
                     end else begin
                        state_q   <= RX_TLP;
                        seq_q     <= {b[2], b[3]};
                        tstamp_q  <= {b[4], b[5], b[6], b[7]};
                        frm_ovf_q <= 1'b0;
                     end
                  end else begin
                     state_q <= RX_HDR;
                     beat_q  <= beat_q + 3'd1;
                  end
               end
            end
            RX_TLP: begin
               if (eth_tvalid) begin
                  if (full) begin
                     ovf_q     <= 1'b1;
                     frm_ovf_q <= 1'b1;
                  end else begin
                     wr_en_q     <= 1'b1;
                     din_tdata_q <= perm_data;
                     din_tkeep_q <= perm_keep;
                     din_tlast_q <= eth_tlast;
                     din_tuser_q <= eth_tlast & eth_tuser;
                  end
                  if (eth_tlast) begin
                     // A frame that lost any payload beat is counted as dropped.
                     if (full || frm_ovf_q) begin
                        drop_cnt_q <= drop_cnt_q + 32'd1;
                     end else begin
                        pkt_cnt_q <= pkt_cnt_q + 32'd1;
                     end
                     state_q <= RX_IDLE;
                  end
               end
            end
            RX_DROP: begin
               if (eth_tvalid && eth_tlast) begin
                  drop_cnt_q <= drop_cnt_q + 32'd1;
                  state_q    <= RX_IDLE;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign wr_en         = wr_en_q;
   assign din_tdata     = din_tdata_q;
   assign din_tkeep     = din_tkeep_q;
   assign din_tlast     = din_tlast_q;
   assign din_tuser     = din_tuser_q;
   assign rx_seq        = seq_q;
   assign rx_tstamp     = tstamp_q;
   assign rx_pkt_count  = pkt_cnt_q;
   assign rx_drop_count = drop_cnt_q;
   assign rx_ovf        = ovf_q;

endmodule

// File: tb/tb_eth_decap.sv
// Bench for eth_decap: table of directed frames, reset/runt sequences and
// randomized back-to-back frames against a frame-level reference model.
module tb_eth_decap;

   localparam logic [47:0] LMAC  = 48'h02_11_22_33_44_55;
   localparam logic [31:0] LIP   = 32'hC0A8_0102;
   localparam logic [15:0] PROTO = 16'h0800;
   localparam logic [15:0] DPORT = 16'h3000;

   logic        clk = 1'b0;
   logic        eth_rst = 1'b1;
   logic        eth_tvalid = 1'b0;
   logic        eth_tlast = 1'b0;
   logic [7:0]  eth_tkeep = 8'h00;
   logic [63:0] eth_tdata = 64'h0;
   logic        eth_tuser = 1'b0;
   logic        full = 1'b0;
   logic        prog_full = 1'b0;
   logic        wr_en;
   logic [63:0] din_tdata;
   logic [7:0]  din_tkeep;
   logic        din_tlast;
   logic        din_tuser;
   logic [15:0] rx_seq;
   logic [31:0] rx_tstamp;
   logic [31:0] rx_pkt_count;
   logic [31:0] rx_drop_count;
   logic        rx_ovf;

   always #5 clk = ~clk;

   eth_decap #(.eth_proto(PROTO), .udp_dport(DPORT)) dut (
      .eth_clk(clk), .eth_rst(eth_rst),
      .eth_tvalid(eth_tvalid), .eth_tlast(eth_tlast), .eth_tkeep(eth_tkeep),
      .eth_tdata(eth_tdata), .eth_tuser(eth_tuser),
      .adapter_reg_srcmac(LMAC), .adapter_reg_srcip(LIP),
      .wr_en(wr_en), .din_tdata(din_tdata), .din_tkeep(din_tkeep),
      .din_tlast(din_tlast), .din_tuser(din_tuser),
      .full(full), .prog_full(prog_full),
      .rx_seq(rx_seq), .rx_tstamp(rx_tstamp), .rx_pkt_count(rx_pkt_count),
      .rx_drop_count(rx_drop_count), .rx_ovf(rx_ovf)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } wr_t;

   wr_t got[$];
   int  gcyc[$];
   wr_t expq[$];

   // FIFO-side monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         got.push_back({din_tdata, din_tkeep, din_tlast, din_tuser});
         gcyc.push_back(cyc);
      end
   end

   // Current frame under construction.
   logic [7:0] fb [128];
   bit         fpf [16];
   bit         ffull [16];
   bit         ftu [16];
   logic [7:0] fkeep_last;
   int         fnb;

   // Reference model state.
   logic [31:0] m_pkt = 0;
   logic [31:0] m_drop = 0;
   logic        m_ovf = 0;
   logic [15:0] m_seq = 0;
   logic [31:0] m_ts = 0;

   typedef struct {
      int          msel;
      logic [15:0] et;
      logic [7:0]  vihl;
      logic [7:0]  pr;
      int          ipm;
      logic [15:0] dp;
      int          nb;
      int          pfb;
      int          fullb;
      bit          tu;
      int          e_wr;
      int          e_pkt;
      int          e_drop;
      int          e_ovf;
   } vec_t;

   vec_t tab [17];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input wr_t act, input wr_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got d=%h k=%h l=%b u=%b expected d=%h k=%h l=%b u=%b",
                  nm, act.d, act.k, act.l, act.u, exp.d, exp.k, exp.l, exp.u);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic build(input int msel, input logic [15:0] et, input logic [7:0] vihl,
                        input logic [7:0] pr, input int ipm, input logic [15:0] dp,
                        input int nb, input int pfb, input int fullb, input bit tu);
      logic [47:0] m;
      logic [31:0] ip;
      for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
      m = (msel == 0) ? LMAC : (msel == 1) ? 48'hFFFF_FFFF_FFFF : (LMAC ^ 48'h1);
      for (int i = 0; i < 6; i++) fb[i] = m[47-8*i -: 8];
      fb[12] = et[15:8];
      fb[13] = et[7:0];
      fb[14] = vihl;
      fb[23] = pr;
      ip = (ipm == 1) ? (LIP ^ 32'h0100_0000) : (ipm == 2) ? (LIP ^ 32'h1) : LIP;
      for (int i = 0; i < 4; i++) fb[30+i] = ip[31-8*i -: 8];
      fb[36] = dp[15:8];
      fb[37] = dp[7:0];
      fnb = nb;
      for (int i = 0; i < 16; i++) begin
         fpf[i]   = (i == pfb);
         ffull[i] = (i == fullb);
         ftu[i]   = 1'($urandom_range(0, 1));
      end
      ftu[nb-1]  = tu;
      fkeep_last = 8'hFF >> $urandom_range(0, 7);
   endtask

   function automatic logic [63:0] lanes(input int base);
      return {fb[base+4], fb[base+5], fb[base+6], fb[base+7],
              fb[base],   fb[base+1], fb[base+2], fb[base+3]};
   endfunction

   // Frame-level model: judge the whole header at once, then list the writes.
   task automatic model();
      logic [47:0] dmac;
      logic [15:0] et;
      logic [15:0] dp;
      logic [31:0] da;
      logic [7:0]  kk;
      bit          ok;
      bit          anyfull;
      wr_t         w;
      dmac = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
      et   = {fb[12], fb[13]};
      da   = {fb[30], fb[31], fb[32], fb[33]};
      dp   = {fb[36], fb[37]};
      ok = ((dmac == LMAC) || (dmac == 48'hFFFF_FFFF_FFFF)) && (et == PROTO) &&
           (fb[14] == 8'h45) && (fb[23] == 8'd17) && (da == LIP) &&
           (int'(dp) >= int'(DPORT)) && (int'(dp) <= int'(DPORT) + 15);
      if (!ok || fnb <= 6 || fpf[5]) begin
         m_drop++;
         return;
      end
      m_seq = {fb[42], fb[43]};
      m_ts  = {fb[44], fb[45], fb[46], fb[47]};
      anyfull = 1'b0;
      for (int i = 6; i < fnb; i++) begin
         if (ffull[i]) begin
            anyfull = 1'b1;
            m_ovf   = 1'b1;
         end else begin
            kk  = (i == fnb - 1) ? fkeep_last : 8'hFF;
            w.d = lanes(8 * i);
            w.k = {kk[4], kk[5], kk[6], kk[7], kk[0], kk[1], kk[2], kk[3]};
            w.l = (i == fnb - 1);
            w.u = (i == fnb - 1) ? ftu[i] : 1'b0;
            expq.push_back(w);
         end
      end
      if (anyfull) m_drop++;
      else m_pkt++;
   endtask

   task automatic drive_beat(input int i);
      eth_tvalid = 1'b1;
      for (int k = 0; k < 8; k++) eth_tdata[8*k +: 8] = fb[8*i + k];
      eth_tkeep  = (i == fnb - 1) ? fkeep_last : 8'hFF;
      eth_tlast  = (i == fnb - 1);
      eth_tuser  = ftu[i];
      full       = ffull[i];
      prog_full  = fpf[i];
      @(posedge clk); #1;
      eth_tvalid = 1'b0;
      eth_tlast  = 1'b0;
      full       = 1'b0;
      prog_full  = 1'b0;
   endtask

   task automatic send(input int maxgap, output int t0);
      t0 = 0;
      for (int i = 0; i < fnb; i++) begin
         if (maxgap > 0) begin
            repeat ($urandom_range(0, maxgap)) begin
               eth_tvalid = 1'b0;
               eth_tdata  = {$urandom, $urandom};
               eth_tlast  = 1'($urandom_range(0, 1));
               eth_tuser  = 1'($urandom_range(0, 1));
               full       = 1'($urandom_range(0, 1));
               prog_full  = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
         end
         if (i == 0) t0 = cyc;
         drive_beat(i);
      end
   endtask

   task automatic verify(input string tag);
      chk($sformatf("%s nwr", tag), 64'(got.size()), 64'(expq.size()));
      for (int i = 0; i < got.size() && i < expq.size(); i++)
         chkw($sformatf("%s wr%0d", tag, i), got[i], expq[i]);
      chk($sformatf("%s pkt", tag),  64'(rx_pkt_count),  64'(m_pkt));
      chk($sformatf("%s drop", tag), 64'(rx_drop_count), 64'(m_drop));
      chk($sformatf("%s ovf", tag),  64'(rx_ovf),        64'(m_ovf));
      chk($sformatf("%s seq", tag),  64'(rx_seq),        64'(m_seq));
      chk($sformatf("%s ts", tag),   64'(rx_tstamp),     64'(m_ts));
      got.delete();
      gcyc.delete();
      expq.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk($sformatf("%s wr_en", tag),     64'(wr_en),         64'(0));
      chk($sformatf("%s din_tdata", tag), din_tdata,          64'(0));
      chk($sformatf("%s din_tkeep", tag), 64'(din_tkeep),     64'(0));
      chk($sformatf("%s din_tlast", tag), 64'(din_tlast),     64'(0));
      chk($sformatf("%s din_tuser", tag), 64'(din_tuser),     64'(0));
      chk($sformatf("%s rx_seq", tag),    64'(rx_seq),        64'(0));
      chk($sformatf("%s rx_tstamp", tag), 64'(rx_tstamp),     64'(0));
      chk($sformatf("%s pkt", tag),       64'(rx_pkt_count),  64'(0));
      chk($sformatf("%s drop", tag),      64'(rx_drop_count), 64'(0));
      chk($sformatf("%s ovf", tag),       64'(rx_ovf),        64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int tpkt;
      int tdrop;
      int tovf;
      int msel;
      int ipm;
      logic [15:0] et;
      logic [7:0]  vihl;
      logic [7:0]  pr;
      logic [15:0] dp;

      //       msel et     vihl   pr      ipm dp        nb pfb fullb tu   wr pkt drop ovf
      tab[0]  = '{0, PROTO, 8'h45, 8'd17, 0, 16'h3003, 9,  -1, -1, 1'b0, 3, 1, 0, 0};
      tab[1]  = '{1, PROTO, 8'h45, 8'd17, 0, 16'h300F, 7,  -1, -1, 1'b0, 1, 1, 0, 0};
      tab[2]  = '{0, PROTO, 8'h45, 8'd17, 0, 16'h3010, 9,  -1, -1, 1'b0, 0, 0, 1, 0};
      tab[3]  = '{0, PROTO, 8'h45, 8'd17, 0, 16'h2FFF, 9,  -1, -1, 1'b0, 0, 0, 1, 0};
      tab[4]  = '{0, PROTO, 8'h45, 8'd17, 0, 16'h3000, 8,  -1, -1, 1'b0, 2, 1, 0, 0};
      tab[5]  = '{2, PROTO, 8'h45, 8'd17, 0, 16'h3003, 9,  -1, -1, 1'b0, 0, 0, 1, 0};
      tab[6]  = '{0, 16'h86DD, 8'h45, 8'd17, 0, 16'h3003, 9, -1, -1, 1'b0, 0, 0, 1, 0};
      tab[7]  = '{0, PROTO, 8'h46, 8'd17, 0, 16'h3003, 9,  -1, -1, 1'b0, 0, 0, 1, 0};
      tab[8]  = '{0, PROTO, 8'h45, 8'd6,  0, 16'h3003, 9,  -1, -1, 1'b0, 0, 0, 1, 0};
      tab[9]  = '{0, PROTO, 8'h45, 8'd17, 1, 16'h3003, 9,  -1, -1, 1'b0, 0, 0, 1, 0};
      tab[10] = '{0, PROTO, 8'h45, 8'd17, 2, 16'h3003, 9,  -1, -1, 1'b0, 0, 0, 1, 0};
      tab[11] = '{0, PROTO, 8'h45, 8'd17, 0, 16'h3003, 5,  -1, -1, 1'b0, 0, 0, 1, 0};
      tab[12] = '{0, PROTO, 8'h45, 8'd17, 0, 16'h3003, 6,  -1, -1, 1'b0, 0, 0, 1, 0};
      tab[13] = '{0, PROTO, 8'h45, 8'd17, 0, 16'h3003, 9,   5, -1, 1'b0, 0, 0, 1, 0};
      tab[14] = '{0, PROTO, 8'h45, 8'd17, 0, 16'h3003, 8,   4, -1, 1'b0, 2, 1, 0, 0};
      tab[15] = '{0, PROTO, 8'h45, 8'd17, 0, 16'h3003, 8,  -1, -1, 1'b1, 2, 1, 0, 0};
      tab[16] = '{0, PROTO, 8'h45, 8'd17, 0, 16'h3003, 10, -1,  8, 1'b0, 3, 0, 1, 1};

      // Reset state.
      eth_rst = 1'b1;
      idle(3);
      chk_zero("reset");
      eth_rst = 1'b0;
      idle(2);

      // Directed table, no gaps.
      tpkt = 0; tdrop = 0; tovf = 0;
      for (int v = 0; v < 17; v++) begin
         build(tab[v].msel, tab[v].et, tab[v].vihl, tab[v].pr, tab[v].ipm, tab[v].dp,
               tab[v].nb, tab[v].pfb, tab[v].fullb, tab[v].tu);
         model();
         send(0, t0);
         idle(3);
         tpkt  += tab[v].e_pkt;
         tdrop += tab[v].e_drop;
         tovf   = tovf | tab[v].e_ovf;
         chk($sformatf("tab%0d nwr_tab", v), 64'(got.size()),     64'(tab[v].e_wr));
         chk($sformatf("tab%0d pkt_tab", v), 64'(rx_pkt_count),   64'(tpkt));
         chk($sformatf("tab%0d drop_tab", v), 64'(rx_drop_count), 64'(tdrop));
         chk($sformatf("tab%0d ovf_tab", v), 64'(rx_ovf),         64'(tovf));
         if (tab[v].e_wr > 0 && got.size() > 0) begin
            chk($sformatf("tab%0d latency", v), 64'(gcyc[0] - t0), 64'(7));
            chk($sformatf("tab%0d last", v),  64'(got[got.size()-1].l), 64'(1));
            chk($sformatf("tab%0d tuser", v), 64'(got[got.size()-1].u), 64'(tab[v].tu));
         end
         verify($sformatf("tab%0d", v));
      end

      // Runt (tlast on beat 4) immediately followed by a valid frame.
      build(0, PROTO, 8'h45, 8'd17, 0, 16'h3003, 5, -1, -1, 1'b0);
      model();
      send(0, t0);
      build(0, PROTO, 8'h45, 8'd17, 0, 16'h3005, 9, -1, -1, 1'b1);
      model();
      send(0, t0);
      idle(3);
      verify("runt+next");

      // Reset while TLP beat 1 is on the bus.
      build(0, PROTO, 8'h45, 8'd17, 0, 16'h3003, 10, -1, -1, 1'b0);
      for (int i = 0; i < 7; i++) drive_beat(i);
      @(negedge clk); #1;
      chk("rst prewrite", 64'(got.size()), 64'(1));
      got.delete();
      gcyc.delete();
      expq.delete();
      eth_tvalid = 1'b1;
      for (int k = 0; k < 8; k++) eth_tdata[8*k +: 8] = fb[56 + k];
      eth_tkeep = 8'hFF;
      eth_rst   = 1'b1;
      @(posedge clk); #1;
      eth_rst    = 1'b0;
      eth_tvalid = 1'b0;
      chk_zero("midrst");
      // Remaining beats now form a new frame whose beat 0 is not our MAC.
      for (int i = 64; i < 70; i++) fb[i] = 8'h00;
      drive_beat(8);
      drive_beat(9);
      idle(3);
      m_pkt = 0; m_drop = 1; m_ovf = 0; m_seq = 0; m_ts = 0;
      verify("postrst");

      // Randomized back-to-back frames with gaps.
      for (int f = 0; f < 60; f++) begin
         msel = ($urandom_range(0, 9) < 6) ? 0 : ($urandom_range(0, 3) == 0) ? 2 : 1;
         et   = ($urandom_range(0, 9) == 0) ? 16'h86DD : PROTO;
         vihl = ($urandom_range(0, 9) == 0) ? 8'h46 : 8'h45;
         pr   = ($urandom_range(0, 9) == 0) ? 8'd6 : 8'd17;
         ipm  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
         dp   = 16'(int'(DPORT) - 2 + int'($urandom_range(0, 19)));
         build(msel, et, vihl, pr, ipm, dp, int'($urandom_range(1, 14)), -1, -1,
               1'($urandom_range(0, 1)));
         for (int i = 0; i < 16; i++) begin
            fpf[i]   = ($urandom_range(0, 7) == 0);
            ffull[i] = ($urandom_range(0, 11) == 0);
         end
         model();
         send(2, t0);
         if (f % 5 == 4) begin
            idle(3);
            verify($sformatf("rnd%0d", f));
         end
      end

      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eth_decap.md
ETH_DECAP -- requirements
Module: eth_decap

Interface
REQ-001 SHALL have parameter eth_proto, default 16'h0800, the accepted EtherType.
REQ-002 SHALL have parameter udp_dport, default 16'h3000, the base of the accepted TLP UDP destination-port window.
REQ-003 SHALL have ports: eth_clk in 1 (sole clock); eth_rst in 1 (reset, synchronous, active-high).
REQ-004 SHALL have input ports: eth_tvalid in 1; eth_tlast in 1; eth_tkeep in 8; eth_tdata in 64; eth_tuser in 1 (MAC bad-frame flag, meaningful only with tlast).
REQ-005 SHALL have input ports: adapter_reg_srcmac in 48 (local MAC); adapter_reg_srcip in 32 (local IP).
REQ-006 SHALL have TLP FIFO write ports: wr_en out 1; din_tdata out 64; din_tkeep out 8; din_tlast out 1; din_tuser out 1 (error); full in 1; prog_full in 1.
REQ-007 SHALL have status outputs: rx_seq out 16 (last accepted NetTLP seq); rx_tstamp out 32; rx_pkt_count out 32; rx_drop_count out 32; rx_ovf out 1 (sticky overflow).

Function
REQ-008 SHALL follow this input convention: no tready, one beat per cycle when eth_tvalid=1; frame byte k of a beat is eth_tdata[8k+7:8k].
REQ-009 SHALL treat beats 0-5 (48 bytes: Eth 14, IPv4 20, UDP 8, NetTLP seq 2 + tstamp 4) as header and beats 6.. as TLP payload.
REQ-010 SHALL implement states RX_IDLE, RX_HDR, RX_TLP, RX_DROP, with a 3-bit beat counter cleared in RX_IDLE.
REQ-011 SHALL transition RX_IDLE -> RX_HDR on a valid beat 0 (counter=1), or -> RX_DROP if that beat fails a check.
REQ-012 SHALL apply these header checks, each on the beat where the field completes: dst MAC == adapter_reg_srcmac or FF:FF:FF:FF:FF:FF; EtherType == eth_proto; version=4, ihl=5; protocol=17; IP daddr (beats 3-4) == adapter_reg_srcip; UDP dest in [udp_dport, udp_dport+15].
REQ-013 SHALL take RX_HDR -> RX_DROP on any failed check, on tlast before beat 6 (runt), or on prog_full=1 at beat 5; otherwise beat 5 -> RX_TLP.
REQ-014 SHALL latch the NetTLP seq/tstamp (beat 5, big-endian) into rx_seq/rx_tstamp only when the frame enters RX_TLP.
REQ-015 SHALL in RX_TLP register each valid beat into the FIFO with wr_en 1 cycle after the input beat, where din_tdata[31:0]={b0,b1,b2,b3} and din_tdata[63:32]={b4,b5,b6,b7} (b0 most significant).
REQ-016 SHALL permute din_tkeep with the same byte mapping as din_tdata, and set din_tlast=eth_tlast.
REQ-017 SHALL set din_tuser=eth_tuser on the tlast beat and 0 otherwise.
REQ-018 SHALL suppress wr_en in RX_TLP when full=1, set rx_ovf, and on the suppressed beat's tlast return to RX_IDLE with rx_drop_count+1 and no rx_pkt_count increment.
REQ-019 SHALL on an accepted frame's tlast increment rx_pkt_count and return to RX_IDLE.
REQ-020 SHALL in RX_DROP discard beats with no writes, and on tlast increment rx_drop_count and return to RX_IDLE.
REQ-021 SHALL process a tlast on any beat and a beat-0 of the next frame on the following cycle with no lost beats.
REQ-022 SHALL let counters wrap modulo 2^32.
REQ-023 SHALL hold state when eth_tvalid=0 mid-frame (gaps allowed).

Reset
REQ-024 SHALL on eth_rst=1 force state RX_IDLE, wr_en=0, din_*=0, rx_seq=0, rx_tstamp=0, counters=0 and rx_ovf=0 on the next edge.
REQ-025 SHALL on reset mid-frame abandon the frame with no further writes and treat the next eth_tvalid after reset as beat 0.

Verification
REQ-026 SHALL cover a valid frame, dst MAC=local, IP=local, dport=0x3003, 3 TLP beats, prog_full=0: 3 wr_en pulses starting 7 cycles after beat 0, last with din_tlast=1, rx_pkt_count=1.
REQ-027 SHALL cover a UDP dport of 0x3010: zero writes, rx_drop_count=1.
REQ-028 SHALL cover a runt with tlast on beat 4: zero writes, drop+1, and an immediately following valid frame accepted.
REQ-029 SHALL cover prog_full=1 at beat 5: frame dropped; and full=1 during TLP beat 2: that beat not written, rx_ovf=1, drop+1.
REQ-030 SHALL cover eth_tuser=1 on tlast of an accepted frame: last write has din_tuser=1.
REQ-031 SHALL cover eth_rst asserted during TLP beat 1: no further wr_en, all status outputs 0.
